// File: rtl/ga_req_arbiter.sv
// Round-robin arbiter sharing one GA coprocessor between NumReq requesters,
// with one operation in flight and a watchdog that turns a hung operation into an error.
module ga_req_arbiter #(
  parameter int NumReq        = 4,
  parameter int ReqWidth      = 64,
  parameter int RespWidth     = 32,
  parameter int TimeoutCycles = 256,
  parameter int IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*ReqWidth-1:0] req_data_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic [NumReq-1:0]          resp_valid_o,
  output logic [RespWidth-1:0]       resp_data_o,
  output logic                       resp_error_o,
  output logic                       ga_req_valid_o,
  output logic [ReqWidth-1:0]        ga_req_data_o,
  input  logic                       ga_req_ready_i,
  input  logic                       ga_resp_valid_i,
  input  logic [RespWidth-1:0]       ga_resp_data_i,
  input  logic                       ga_resp_error_i,
  output logic                       busy_o,
  output logic [IdWidth-1:0]         owner_o,
  output logic [15:0]                timeout_cnt_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam int WdWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit WdEnable = (TimeoutCycles != 0);

  logic [1:0]           state_r;
  logic [1:0]           state_next_s;
  logic [IdWidth-1:0]   last_grant_r;
  logic [IdWidth-1:0]   owner_r;
  logic [IdWidth-1:0]   winner_s;
  logic                 win_found_s;
  logic                 accept_s;
  logic                 wd_expire_s;
  logic [ReqWidth-1:0]  payload_r;
  logic [WdWidth-1:0]   wd_cnt_r;
  logic [NumReq-1:0]    resp_valid_r;
  logic [RespWidth-1:0] resp_data_r;
  logic                 resp_error_r;
  logic [15:0]          timeout_cnt_r;

  function automatic logic [NumReq-1:0] onehot(input logic [IdWidth-1:0] id);
    onehot = {{(NumReq-1){1'b0}}, 1'b1} << id;
  endfunction

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    int   idx;
    logic hit;
    idx         = 0;
    hit         = 1'b0;
    winner_s    = {IdWidth{1'b0}};
    win_found_s = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      idx         = (int'(last_grant_r) + 1 + i) % NumReq;
      hit         = req_valid_i[idx] & ~win_found_s;
      winner_s    = hit ? IdWidth'(idx) : winner_s;
      win_found_s = win_found_s | hit;
    end
  end

  assign accept_s    = (state_r == StIdle) && win_found_s;
  // A response arriving on the limit cycle takes precedence over the timeout.
  assign wd_expire_s = WdEnable && (state_r == StWait) && !ga_resp_valid_i && (wd_cnt_r == WdLimit);

  // Next-state selection for the grant/issue/wait/respond sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      StIdle:  state_next_s = win_found_s ? StIssue : StIdle;
      StIssue: state_next_s = ga_req_ready_i ? StWait : StIssue;
      StWait:  state_next_s = (ga_resp_valid_i || wd_expire_s) ? StResp : StWait;
      StResp:  state_next_s = StIdle;
      default: state_next_s = StIdle;
    endcase
  end

  // State, grant bookkeeping, watchdog and response capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= StIdle;
      last_grant_r  <= IdWidth'(NumReq - 1);
      owner_r       <= {IdWidth{1'b0}};
      payload_r     <= {ReqWidth{1'b0}};
      wd_cnt_r      <= {WdWidth{1'b0}};
      resp_valid_r  <= {NumReq{1'b0}};
      resp_data_r   <= {RespWidth{1'b0}};
      resp_error_r  <= 1'b0;
      timeout_cnt_r <= 16'd0;
    end else begin
      state_r      <= state_next_s;
      resp_valid_r <= {NumReq{1'b0}};
      resp_data_r  <= {RespWidth{1'b0}};
      resp_error_r <= 1'b0;
      case (state_r)
        StIdle: begin
          if (win_found_s) begin
            payload_r    <= req_data_i[winner_s*ReqWidth +: ReqWidth];
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
          end
        end
        StIssue: begin
          if (ga_req_ready_i) begin
            wd_cnt_r <= {WdWidth{1'b0}};
          end
        end
        StWait: begin
          if (ga_resp_valid_i) begin
            resp_valid_r <= onehot(owner_r);
            resp_data_r  <= ga_resp_data_i;
            resp_error_r <= ga_resp_error_i;
          end else if (wd_expire_s) begin
            resp_valid_r <= onehot(owner_r);
            resp_error_r <= 1'b1;
            if (timeout_cnt_r != 16'hFFFF) begin
              timeout_cnt_r <= timeout_cnt_r + 16'd1;
            end
          end else begin
            wd_cnt_r <= wd_cnt_r + WdWidth'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Accept is combinational; it is forced low while reset is held.
  assign req_ready_o    = (accept_s && !rst_i) ? onehot(winner_s) : {NumReq{1'b0}};
  assign resp_valid_o   = resp_valid_r;
  assign resp_data_o    = resp_data_r;
  assign resp_error_o   = resp_error_r;
  assign ga_req_valid_o = (state_r == StIssue);
  assign ga_req_data_o  = payload_r;
  assign busy_o         = (state_r != StIdle);
  assign owner_o        = owner_r;
  assign timeout_cnt_o  = timeout_cnt_r;

endmodule

// File: tb/tb_ga_req_arbiter.sv
// Directed bench for ga_req_arbiter: reset, round-robin, backpressure,
// timeout, response/timeout race, coprocessor error and reset mid-operation.
module tb_ga_req_arbiter;

  localparam int NumReq    = 4;
  localparam int ReqWidth  = 64;
  localparam int RespWidth = 32;
  localparam int IdWidth   = 2;

  logic                       clk_i;
  logic                       rst_i;
  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq*ReqWidth-1:0] req_data_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [NumReq-1:0]          resp_valid_o;
  logic [RespWidth-1:0]       resp_data_o;
  logic                       resp_error_o;
  logic                       ga_req_valid_o;
  logic [ReqWidth-1:0]        ga_req_data_o;
  logic                       ga_req_ready_i;
  logic                       ga_resp_valid_i;
  logic [RespWidth-1:0]       ga_resp_data_i;
  logic                       ga_resp_error_i;
  logic                       busy_o;
  logic [IdWidth-1:0]         owner_o;
  logic [15:0]                timeout_cnt_o;

  int n_total;
  int n_bad;

  ga_req_arbiter #(
    .NumReq(NumReq), .ReqWidth(ReqWidth), .RespWidth(RespWidth), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_error_o(resp_error_o),
    .ga_req_valid_o(ga_req_valid_o), .ga_req_data_o(ga_req_data_o),
    .ga_req_ready_i(ga_req_ready_i), .ga_resp_valid_i(ga_resp_valid_i),
    .ga_resp_data_i(ga_resp_data_i), .ga_resp_error_i(ga_resp_error_i),
    .busy_o(busy_o), .owner_o(owner_o), .timeout_cnt_o(timeout_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] payload(input int k);
    payload = 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  // Full transaction with all-valid stimulus held; coprocessor answers in the first WAIT cycle.
  task automatic run_txn(input int exp_id, input logic [31:0] rdata);
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << exp_id;
    #1;
    check_eq("rr_ready", req_ready_o, exp_oh);
    tick();
    ga_req_ready_i = 1'b1;
    #1;
    check_eq("rr_ga_data", ga_req_data_o, payload(exp_id));
    check_eq("rr_no_ready_busy", req_ready_o, 4'b0000);
    tick();
    ga_req_ready_i  = 1'b0;
    ga_resp_valid_i = 1'b1;
    ga_resp_data_i  = rdata;
    tick();
    ga_resp_valid_i = 1'b0;
    ga_resp_data_i  = 32'h0;
    check_eq("rr_resp_valid", resp_valid_o, exp_oh);
    check_eq("rr_owner", owner_o, 64'(exp_id));
    check_eq("rr_resp_data", resp_data_o, rdata);
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_i           = 1'b1;
    req_valid_i     = 4'b0000;
    ga_req_ready_i  = 1'b0;
    ga_resp_valid_i = 1'b0;
    ga_resp_data_i  = 32'h0;
    ga_resp_error_i = 1'b0;
    for (int k = 0; k < NumReq; k++) req_data_i[k*ReqWidth +: ReqWidth] = payload(k);

    // Reset state
    tick();
    tick();
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_resp_valid", resp_valid_o, 4'b0000);
    check_eq("rst_ga_valid", ga_req_valid_o, 1'b0);
    check_eq("rst_ga_data", ga_req_data_o, 64'h0);
    check_eq("rst_owner", owner_o, 2'd0);
    check_eq("rst_tocnt", timeout_cnt_o, 16'd0);
    rst_i = 1'b0;

    // Round-robin: all requesters valid, order 0,1,2,3,0,1,2,3
    req_valid_i = 4'b1111;
    for (int t = 0; t < 8; t++) run_txn(t % NumReq, 32'h100 + 32'(t));
    req_valid_i = 4'b0000;
    tick();

    // Single request from requester 2
    req_data_i[2*ReqWidth +: ReqWidth] = 64'hA5;
    req_valid_i    = 4'b0100;
    ga_req_ready_i = 1'b1;
    #1;
    check_eq("single_ready", req_ready_o, 4'b0100);
    tick();
    req_valid_i = 4'b0000;
    check_eq("single_ga_valid", ga_req_valid_o, 1'b1);
    check_eq("single_ga_data", ga_req_data_o, 64'hA5);
    tick();
    ga_req_ready_i = 1'b0;
    check_eq("single_wait_ga_valid", ga_req_valid_o, 1'b0);
    tick();
    ga_resp_valid_i = 1'b1;
    ga_resp_data_i  = 32'h1234;
    tick();
    ga_resp_valid_i = 1'b0;
    ga_resp_data_i  = 32'h0;
    check_eq("single_resp_valid", resp_valid_o, 4'b0100);
    check_eq("single_resp_data", resp_data_o, 32'h1234);
    check_eq("single_resp_err", resp_error_o, 1'b0);
    tick();
    check_eq("single_idle_valid", resp_valid_o, 4'b0000);
    check_eq("single_idle_data", resp_data_o, 32'h0);
    check_eq("single_idle_busy", busy_o, 1'b0);

    // Backpressure with wrap-around grant to 0, then coprocessor error
    req_valid_i = 4'b0011;
    #1;
    check_eq("bp_ready", req_ready_o, 4'b0001);
    tick();
    req_data_i[0 +: ReqWidth] = 64'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_ga_valid", ga_req_valid_o, 1'b1);
      check_eq("bp_ga_data", ga_req_data_o, payload(0));
      check_eq("bp_no_ready", req_ready_o, 4'b0000);
      check_eq("bp_busy", busy_o, 1'b1);
      tick();
    end
    req_valid_i    = 4'b0000;
    ga_req_ready_i = 1'b1;
    tick();
    ga_req_ready_i  = 1'b0;
    ga_resp_valid_i = 1'b1;
    ga_resp_data_i  = 32'h0000_DEAD;
    ga_resp_error_i = 1'b1;
    tick();
    ga_resp_valid_i = 1'b0;
    ga_resp_error_i = 1'b0;
    ga_resp_data_i  = 32'h0;
    check_eq("err_resp_valid", resp_valid_o, 4'b0001);
    check_eq("err_resp_data", resp_data_o, 32'h0000_DEAD);
    check_eq("err_resp_err", resp_error_o, 1'b1);
    tick();

    // Timeout: requester 1, coprocessor silent for 8 WAIT cycles
    req_valid_i = 4'b0010;
    #1;
    check_eq("to_ready", req_ready_o, 4'b0010);
    tick();
    req_valid_i    = 4'b0000;
    ga_req_ready_i = 1'b1;
    ga_resp_data_i = 32'hFFFF_FFFF;
    tick();
    ga_req_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check_eq("to_wait_no_resp", resp_valid_o, 4'b0000);
      check_eq("to_wait_busy", busy_o, 1'b1);
      tick();
    end
    check_eq("to_resp_valid", resp_valid_o, 4'b0010);
    check_eq("to_resp_err", resp_error_o, 1'b1);
    check_eq("to_resp_data", resp_data_o, 32'h0);
    check_eq("to_count", timeout_cnt_o, 16'd1);
    tick();
    ga_resp_valid_i = 1'b1;
    tick();
    tick();
    check_eq("stray_no_resp", resp_valid_o, 4'b0000);
    check_eq("stray_idle", busy_o, 1'b0);
    ga_resp_valid_i = 1'b0;
    ga_resp_data_i  = 32'h0;

    // Race: response arrives on the timeout-limit cycle
    req_valid_i = 4'b0100;
    #1;
    check_eq("race_ready", req_ready_o, 4'b0100);
    tick();
    req_valid_i    = 4'b0000;
    ga_req_ready_i = 1'b1;
    tick();
    ga_req_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check_eq("race_pre_no_resp", resp_valid_o, 4'b0000);
    ga_resp_valid_i = 1'b1;
    ga_resp_data_i  = 32'h5A5A;
    tick();
    ga_resp_valid_i = 1'b0;
    ga_resp_data_i  = 32'h0;
    check_eq("race_resp_valid", resp_valid_o, 4'b0100);
    check_eq("race_resp_data", resp_data_o, 32'h5A5A);
    check_eq("race_resp_err", resp_error_o, 1'b0);
    check_eq("race_tocnt", timeout_cnt_o, 16'd1);
    tick();

    // Reset in the middle of WAIT
    req_valid_i = 4'b1000;
    #1;
    check_eq("mid_ready", req_ready_o, 4'b1000);
    tick();
    ga_req_ready_i = 1'b1;
    tick();
    ga_req_ready_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy_o, 1'b0);
    check_eq("mid_rst_ready", req_ready_o, 4'b0000);
    check_eq("mid_rst_owner", owner_o, 2'd0);
    check_eq("mid_rst_tocnt", timeout_cnt_o, 16'd0);
    check_eq("mid_rst_ga_data", ga_req_data_o, 64'h0);
    tick();
    rst_i       = 1'b0;
    req_valid_i = 4'b1001;
    #1;
    check_eq("post_rst_ready", req_ready_o, 4'b0001);
    tick();
    req_valid_i = 4'b0000;
    check_eq("post_rst_owner", owner_o, 2'd0);
    check_eq("post_rst_ga_valid", ga_req_valid_o, 1'b1);
    check_eq("post_rst_no_resp", resp_valid_o, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
